// File: rtl/extend_divider.sv
// Multi-cycle signed divider: restoring shift-subtract on operand magnitudes,
// one quotient bit per clock, followed by a sign fix-up cycle.
module extend_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             zr,
    output logic             ng
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [CW-1:0]    cnt_q;
    logic             qneg_q;
    logic             rneg_q;
    logic             dbz_q;

    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quo_out_q;
    logic [WIDTH-1:0] rem_out_q;
    logic             dbz_out_q;
    logic             zr_q;
    logic             ng_q;

    logic [WIDTH-1:0] x_abs_d;
    logic [WIDTH-1:0] y_abs_d;
    logic [WIDTH:0]   shifted_d;
    logic             ge_d;
    logic [WIDTH-1:0] rem_sub_d;
    logic [WIDTH-1:0] q_res_d;
    logic [WIDTH-1:0] r_res_d;

    // Operand magnitudes, trial subtraction and final signed results.
    always_comb begin
        x_abs_d   = x[WIDTH-1] ? -x : x;
        y_abs_d   = y[WIDTH-1] ? -y : y;
        shifted_d = {rem_q, dvd_q[WIDTH-1]};
        ge_d      = (shifted_d >= {1'b0, dvs_q});
        // The true difference is below the divisor, so the low bits are exact.
        rem_sub_d = shifted_d[WIDTH-1:0] - dvs_q;
        if (dbz_q) begin
            q_res_d = '1;
            r_res_d = dvd_q;
        end else begin
            q_res_d = qneg_q ? -dvd_q : dvd_q;
            r_res_d = rneg_q ? -rem_q : rem_q;
        end
    end

    // Divider FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quo_out_q <= '0;
            rem_out_q <= '0;
            dbz_out_q <= 1'b0;
            zr_q      <= 1'b1;
            ng_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // A zero divisor skips iteration; the raw dividend
                        // rides in the shift register as the remainder.
                        dbz_q   <= (y == '0);
                        dvd_q   <= (y == '0) ? x : x_abs_d;
                        dvs_q   <= y_abs_d;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        qneg_q  <= x[WIDTH-1] ^ y[WIDTH-1];
                        rneg_q  <= x[WIDTH-1];
                        busy_q  <= 1'b1;
                        state_q <= (y == '0) ? FIX : CALC;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    rem_q <= ge_d ? rem_sub_d : shifted_d[WIDTH-1:0];
                    dvd_q <= {dvd_q[WIDTH-2:0], ge_d};
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= FIX;
                    end else begin
                        state_q <= CALC;
                    end
                end
                FIX: begin
                    quo_out_q <= q_res_d;
                    rem_out_q <= r_res_d;
                    dbz_out_q <= dbz_q;
                    zr_q      <= (q_res_d == '0);
                    ng_q      <= q_res_d[WIDTH-1];
                    dbz_q     <= 1'b0;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_out_q;
    assign remainder   = rem_out_q;
    assign div_by_zero = dbz_out_q;
    assign zr          = zr_q;
    assign ng          = ng_q;

endmodule

// File: tb/tb_extend_divider.sv
// Self-checking bench for extend_divider: directed corner cases plus random
// divides compared against an integer-arithmetic reference model.
module tb_extend_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] x;
    logic [15:0] y;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        zr;
    logic        ng;

    int n_checks;
    int n_fail;

    logic [15:0] last_q;
    logic [15:0] last_r;

    extend_divider #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .x           (x),
        .y           (y),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .zr          (zr),
        .ng          (ng)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: truncating signed division, remainder follows the dividend.
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] q, output logic [15:0] r,
                                  output logic z, output int lat);
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (b == 16'd0) begin
            q   = 16'hFFFF;
            r   = a;
            z   = 1'b1;
            lat = 1;
        end else begin
            q   = 16'(sa / sb);
            r   = 16'(sa % sb);
            z   = 1'b0;
            lat = 17;
        end
    endfunction

    // Issue one divide now; returns right after done is observed.
    task automatic do_div(input logic [15:0] a, input logic [15:0] b, input bit noise);
        logic [15:0] eq;
        logic [15:0] er;
        logic        ez;
        int          elat;
        int          edges;
        bit          got;
        model(a, b, eq, er, ez, elat);
        start = 1'b1;
        x     = a;
        y     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (noise) begin
            x = 16'($urandom);
            y = 16'($urandom);
        end
        check("busy_after_accept", 32'(busy), 32'd1);
        edges = 0;
        got   = 1'b0;
        while (edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (done) begin
                got = 1'b1;
                break;
            end
            check("busy_hi", 32'(busy), 32'd1);
            check("q_held", 32'(quotient), 32'(last_q));
            check("r_held", 32'(remainder), 32'(last_r));
            if (noise) begin
                start = 1'($urandom);
                x     = 16'($urandom);
                y     = 16'($urandom);
            end
        end
        start = 1'b0;
        check("done_seen", 32'(got), 32'd1);
        check("latency", 32'(edges), 32'(elat));
        check("busy_at_done", 32'(busy), 32'd0);
        check("quotient", 32'(quotient), 32'(eq));
        check("remainder", 32'(remainder), 32'(er));
        check("div_by_zero", 32'(div_by_zero), 32'(ez));
        check("zr", 32'(zr), 32'(eq == 16'd0));
        check("ng", 32'(ng), 32'(eq[15]));
        last_q = eq;
        last_r = er;
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b, input bit noise);
        do_div(a, b, noise);
        @(posedge clk);
        #1;
        check("done_once", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        int          sel;
        n_checks = 0;
        n_fail   = 0;
        last_q   = 16'd0;
        last_r   = 16'd0;
        rst_n    = 1'b0;
        start    = 1'b0;
        x        = 16'd0;
        y        = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q", 32'(quotient), 32'd0);
        check("rst_r", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        check("rst_zr", 32'(zr), 32'd1);
        check("rst_ng", 32'(ng), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run(16'd100, 16'd7, 1'b0);
        run(-16'sd100, 16'd7, 1'b0);
        run(16'd100, -16'sd7, 1'b0);
        run(-16'sd100, -16'sd7, 1'b0);
        run(16'd3, 16'd5, 1'b0);
        run(16'd1234, 16'd0, 1'b0);
        run(16'd10, 16'd2, 1'b0);
        run(16'h8000, 16'hFFFF, 1'b0);
        run(16'd32767, 16'd1, 1'b0);
        run(16'h8000, 16'd32767, 1'b0);

        // Noisy handshake, then back-to-back issue in the done cycle.
        do_div(16'd500, 16'd3, 1'b1);
        run(16'd9, 16'd4, 1'b0);

        // Reset in the middle of an operation.
        start = 1'b1;
        x     = 16'd1000;
        y     = 16'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_q", 32'(quotient), 32'd0);
        check("mid_rst_r", 32'(remainder), 32'd0);
        check("mid_rst_zr", 32'(zr), 32'd1);
        last_q = 16'd0;
        last_r = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(16'd1000, 16'd3, 1'b0);

        for (int i = 0; i < 30; i++) begin
            ra  = 16'($urandom);
            sel = $urandom_range(0, 5);
            case (sel)
                0:       rb = 16'd0;
                1:       rb = 16'($urandom_range(1, 9));
                2:       rb = 16'hFFFF;
                3:       rb = -16'($urandom_range(1, 9));
                default: rb = 16'($urandom);
            endcase
            run(ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/extend_divider.md
Name: extend_divider

Overview:
- Multi-cycle signed 16-bit divider; the inverse companion of the extended ALU multiply path.
- The CPU issues a divide with a one-cycle start strobe and stalls on busy.
- It collects the quotient and remainder on the done pulse. zr/ng flags match the ALU convention.
- Algorithm: restoring shift-subtract on magnitudes, one quotient bit per cycle, then sign fix-up.

Parameters:
- WIDTH, 16: operand/result width. Iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request strobe; sampled only in IDLE.
- x  input  WIDTH  signed dividend.
- y  input  WIDTH  signed divisor.
- busy  output  1  high from the cycle after accept until the done cycle (exclusive).
- done  output  1  one-cycle completion pulse.
- quotient  output  WIDTH  signed quotient, registered.
- remainder  output  WIDTH  signed remainder, registered.
- div_by_zero  output  1  set with done when y was 0.
- zr  output  1  quotient == 0, registered with quotient.
- ng  output  1  quotient MSB, registered with quotient.

Behaviour:
- Reset (async, rst_n low): state=IDLE. busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, zr=1, ng=0. All internal registers are cleared. Any in-flight operation is discarded with no done pulse. Operation resumes on the first rising edge after rst_n rises.
- States: IDLE, CALC, FIX.
- IDLE, start=1, y!=0 at edge N:
  - Latch |x| into the dividend shift register and |y| as the divisor.
  - Latch sign_q = x[MSB]^y[MSB] and sign_r = x[MSB].
  - Clear the partial remainder and the iteration counter.
  - Go to CALC. busy=1 after edge N.
- IDLE, start=1, y==0 at edge N:
  - No iteration.
  - After edge N+1: quotient=all ones (-1), remainder=x (captured at N), div_by_zero=1, done=1, busy stays 1 only between N and N+1.
  - Flags: zr=0, ng=1.
- CALC, one edge per iteration, WIDTH iterations (edges N+1..N+WIDTH):
  - Shift the partial remainder left, bringing in the dividend MSB.
  - If partial >= divisor: subtract and shift quotient bit 1; else shift 0.
  - The partial remainder is WIDTH+1 bits wide to avoid overflow.
  - The counter runs 0..WIDTH-1. Go to FIX after the last iteration.
- FIX, edge N+WIDTH+1:
  - quotient = sign_q ? -q : q. remainder = sign_r ? -r : r.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Update zr/ng. div_by_zero=0. done=1 for exactly this next cycle. busy=0. Return to IDLE.
- Latency: done is high in the cycle following edge N+WIDTH+1 (17 edges for WIDTH=16). Divide-by-zero takes 1 edge.
- Overflow: -32768 / -1 gives quotient 16'h8000 (wraps), remainder 0, ng=1, zr=0. Magnitudes are held as unsigned WIDTH bits, so |-32768|=32768 is exact.
- start while busy is ignored. No queueing, no error.
- Because state is IDLE during the done cycle, start in the done cycle is accepted (back-to-back issue).
- x/y are sampled only at accept. Later changes have no effect on the operation in flight.
- quotient/remainder/flags hold their last values until the next completion, and are never modified mid-operation.
- done is never high while busy is high.

Test Plan:
- Reset, then 100 / 7 with start pulse at edge N → busy high 17 cycles; done pulses once after edge N+17; quotient=14, remainder=2, zr=0, ng=0, div_by_zero=0.
- Signs: -100/7 → q=-14, r=-2, ng=1. 100/-7 → q=-14, r=2. -100/-7 → q=14, r=-2. 3/5 → q=0, r=3, zr=1.
- Divide by zero: 1234/0 → done after 1 edge; quotient=16'hFFFF, remainder=1234, div_by_zero=1, ng=1. The following 10/2 clears div_by_zero (q=5, r=0).
- Overflow and extremes: -32768/-1 → q=16'h8000, r=0, ng=1. 32767/1 → q=32767, r=0. -32768/32767 → q=-1, r=-1.
- Handshake: during 500/3, toggle start and change x/y every cycle → result still q=166, r=2 with one done pulse. Issuing 9/4 in the done cycle → accepted; second done 17 edges later, q=2, r=1.
- Reset mid-operation: assert rst_n low at iteration 8 of 1000/3 → busy=0, done=0, outputs zero, zr=1. After release, 1000/3 completes normally with q=333, r=1 and no stale done pulse.
